// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Imported by the fetch unit top and its testbench.
package instruction_fetch_unit_pkg;

    localparam logic [31:0] RESET_VECTOR    = 32'h0000_0100;
    localparam logic [31:0] FETCH_BUBBLE    = 32'h0000_0000;
    localparam logic [31:0] WORD_MASK       = 32'hFFFF_FFFC;
    localparam int          PC_STEP_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_DRAIN
    } fetch_state_e;

    // One buffered fetch: {pc, instr}, 64 bits
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] align_word(input logic [31:0] a);
        return a & WORD_MASK;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_fifo.sv
// fetch_fifo: small parametric synchronous FIFO with flush.
// Head is presented combinationally; flush wins over push/pop.
module fetch_fifo #(
    parameter int  WIDTH = 64,
    parameter int  DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CW-1:0]    count_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_q;
    logic [PW-1:0]    wr_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & ((cnt_q != CW'(DEPTH)) | do_pop);

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= bump(wr_q);
            if (do_pop)  rd_q <= bump(rd_q);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Entry storage needs no reset; occupancy guards every read
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the fetch PC, issues imem requests under a credit limit,
// buffers responses and presents {instruction, pc} to IF/ID.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int          FIFO_DEPTH = 2,
    parameter int          PC_STEP    = PC_STEP_DEFAULT,
    parameter logic [31:0] RESET_PC   = RESET_VECTOR
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stall_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instruction_if_o,
    output logic [31:0] pc_if_o
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_e  state_q;
    logic [31:0]   fetch_pc_q;
    logic [CW-1:0] discard_q;

    logic [CW-1:0] fifo_cnt;
    logic [CW-1:0] outstanding;
    logic          fifo_empty;
    logic          ipc_empty;
    fetch_entry_t  fifo_head;
    fetch_entry_t  fifo_push_data;
    logic [31:0]   ipc_head;
    logic          redir;
    logic          retire;
    logic          issue;
    logic          fifo_push;
    logic          fifo_pop;
    logic          rvalid_stray;
    logic [CW:0]   inflight;
    logic [CW-1:0] discard_new;

    assign redir        = redirect_valid_i & (state_q != ST_BOOT);
    assign rvalid_stray = imem_rvalid_i & ipc_empty;
    assign retire       = imem_rvalid_i & ~rvalid_stray;
    assign fifo_pop     = ~fifo_empty & ~stall_i & ~redir;
    assign fifo_push    = retire & (discard_q == '0) & ~redir;

    // The head leaving this cycle frees its slot, so a 1-cycle memory
    // streams at full rate with only two entries.
    assign inflight = (CW + 1)'(fifo_cnt) + (CW + 1)'(outstanding)
                    - (CW + 1)'(fifo_pop);

    assign imem_req_o  = (state_q == ST_RUN) & ~redir
                       & (inflight < (CW + 1)'(FIFO_DEPTH));
    assign imem_addr_o = fetch_pc_q;
    assign issue       = imem_req_o & imem_gnt_i;
    assign discard_new = outstanding + CW'(issue) - CW'(retire);

    assign fifo_push_data = '{pc: ipc_head, instr: imem_rdata_i};

    assign instruction_if_o = (!fifo_empty && !redir) ? fifo_head.instr
                                                      : FETCH_BUBBLE;
    assign pc_if_o          = (!fifo_empty && !redir) ? fifo_head.pc
                                                      : FETCH_BUBBLE;

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_resp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifo_push),
        .data_i  (fifo_push_data),
        .pop_i   (fifo_pop),
        .flush_i (redir),
        .head_o  (fifo_head),
        .count_o (fifo_cnt),
        .empty_o (fifo_empty)
    );

    // Issue-PC queue: its occupancy is the outstanding-request count
    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_issue_pc (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (issue),
        .data_i  (fetch_pc_q),
        .pop_i   (retire),
        .flush_i (1'b0),
        .head_o  (ipc_head),
        .count_o (outstanding),
        .empty_o (ipc_empty)
    );

    // Fetch FSM: PC advance, redirect reload and drain of stale responses
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_BOOT;
            fetch_pc_q <= RESET_PC;
            discard_q  <= '0;
        end else begin
            unique case (state_q)
                ST_BOOT: state_q <= ST_RUN;
                ST_RUN, ST_DRAIN: begin
                    if (redir) begin
                        fetch_pc_q <= align_word(redirect_pc_i);
                        discard_q  <= discard_new;
                        state_q    <= (discard_new != '0) ? ST_DRAIN : ST_RUN;
                    end else begin
                        if (issue) fetch_pc_q <= fetch_pc_q + 32'(PC_STEP);
                        if (retire && discard_q != '0) begin
                            discard_q <= discard_q - CW'(1);
                            if (discard_q == CW'(1)) state_q <= ST_RUN;
                        end
                    end
                end
                default: state_q <= ST_BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed testbench for instruction_fetch_unit with a 1-cycle in-order
// memory model that can hold responses back to build in-flight requests.
module tb_instruction_fetch_unit;
    import instruction_fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instruction_if;
    logic [31:0] pc_if;

    int          n_tests = 0;
    int          n_fail = 0;
    int          stray_cnt = 0;
    logic        mem_hold = 1'b0;
    logic        hold_req = 1'b0;
    logic [31:0] pend[$];

    instruction_fetch_unit dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .stall_i          (stall),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .imem_req_o       (imem_req),
        .imem_addr_o      (imem_addr),
        .imem_gnt_i       (imem_gnt),
        .imem_rvalid_i    (imem_rvalid),
        .imem_rdata_i     (imem_rdata),
        .instruction_if_o (instruction_if),
        .pc_if_o          (pc_if)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    // Memory: grant recorded mid-cycle, data returned the following cycle
    always @(negedge clk) begin
        if (!mem_hold && pend.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
        if (rst_n && imem_req && imem_gnt) pend.push_back(imem_addr);
    end

    always @(posedge clk) begin
        if (rst_n && dut.rvalid_stray) begin
            stray_cnt++;
            $display("[TB] protocol error: rvalid with nothing outstanding at %0t", $time);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic s, input logic rv, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        stall          = s;
        redirect_valid = rv;
        redirect_pc    = rpc;
        mem_hold       = hold_req;
        @(negedge clk);
    endtask

    initial begin
        // T1 reset and boot
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_instr", instruction_if, 32'h0);
        chk("rst_pc", pc_if, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("boot_req", 32'(imem_req), 32'd0);
        cyc(0, 0, '0);
        chk("t1_req", 32'(imem_req), 32'd1);
        chk("t1_addr", imem_addr, RESET_VECTOR);
        cyc(0, 0, '0);
        chk("t1_bubble", instruction_if, 32'h0);
        chk("t1_addr2", imem_addr, 32'h104);

        // T2 stream of 8 words
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, '0);
            chk("t2_pc", pc_if, 32'h100 + 32'(4 * i));
            chk("t2_instr", instruction_if, mem_word(32'h100 + 32'(4 * i)));
            chk("t2_req", 32'(imem_req), 32'd1);
        end

        // T3 stall with full FIFO
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, '0);
            chk("t3_pc", pc_if, 32'h120);
            chk("t3_instr", instruction_if, mem_word(32'h120));
            chk("t3_req", 32'(imem_req), 32'd0);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, '0);
            chk("t3_resume", pc_if, 32'h120 + 32'(4 * i));
        end

        // T5 redirect and stall together
        cyc(1, 1, 32'h303);
        chk("t5_instr", instruction_if, 32'h0);
        chk("t5_pc", pc_if, 32'h0);
        chk("t5_req", 32'(imem_req), 32'd0);
        cyc(0, 0, '0);
        chk("t5_req1", 32'(imem_req), 32'd1);
        chk("t5_addr", imem_addr, 32'h300);
        chk("t5_flushed", instruction_if, 32'h0);
        cyc(0, 0, '0);
        chk("t5_bubble", pc_if, 32'h0);
        cyc(0, 0, '0);
        chk("t5_pc_new", pc_if, 32'h300);
        chk("t5_instr_new", instruction_if, mem_word(32'h300));

        // T4 redirect with two requests in flight
        hold_req = 1'b1;
        cyc(0, 0, '0);
        chk("t4_pc", pc_if, 32'h304);
        chk("t4_addr", imem_addr, 32'h30C);
        cyc(0, 1, 32'h200);
        chk("t4_redir_req", 32'(imem_req), 32'd0);
        chk("t4_redir_out", instruction_if, 32'h0);
        hold_req = 1'b0;
        cyc(0, 0, '0);
        chk("t4_drain1", 32'(dut.state_q), 32'(ST_DRAIN));
        chk("t4_drain1_out", instruction_if, 32'h0);
        chk("t4_drain1_req", 32'(imem_req), 32'd0);
        cyc(0, 0, '0);
        chk("t4_drain2", 32'(dut.state_q), 32'(ST_DRAIN));
        chk("t4_drain2_pc", pc_if, 32'h0);
        cyc(0, 0, '0);
        chk("t4_run", 32'(dut.state_q), 32'(ST_RUN));
        chk("t4_req", 32'(imem_req), 32'd1);
        chk("t4_addr_new", imem_addr, 32'h200);
        cyc(0, 0, '0);
        chk("t4_bubble", instruction_if, 32'h0);
        cyc(0, 0, '0);
        chk("t4_pc_new", pc_if, 32'h200);
        chk("t4_instr_new", instruction_if, mem_word(32'h200));

        // T6 asynchronous reset in the middle of a drain
        hold_req = 1'b1;
        cyc(0, 0, '0);
        chk("t6_pc", pc_if, 32'h204);
        cyc(0, 1, 32'h400);
        hold_req = 1'b0;
        cyc(0, 0, '0);
        chk("t6_drain", 32'(dut.state_q), 32'(ST_DRAIN));
        @(posedge clk);
        #1;
        mem_hold = 1'b1;
        hold_req = 1'b1;
        chk("t6_discard", 32'(dut.discard_q), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_state", 32'(dut.state_q), 32'(ST_BOOT));
        chk("t6_instr", instruction_if, 32'h0);
        chk("t6_pc0", pc_if, 32'h0);
        chk("t6_req0", 32'(imem_req), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        mem_hold = 1'b0;
        hold_req = 1'b0;
        @(negedge clk);
        chk("t6_boot_req", 32'(imem_req), 32'd0);
        cyc(0, 0, '0);
        chk("t6_stray", 32'(stray_cnt), 32'd1);
        chk("t6_req", 32'(imem_req), 32'd1);
        chk("t6_addr", imem_addr, RESET_VECTOR);
        cyc(0, 0, '0);
        chk("t6_bubble", instruction_if, 32'h0);
        cyc(0, 0, '0);
        chk("t6_pc_rv", pc_if, RESET_VECTOR);
        chk("t6_instr_rv", instruction_if, mem_word(RESET_VECTOR));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
